// File: rtl/mem_req_queue.sv
// DEPTH-entry request FIFO between the operand collector and mem stage 1; computes per-lane
// effective addresses and a uniform-address flag at enqueue. Optional stats: MEM_REQ_QUEUE_STATS_EN.
module mem_req_queue #(
    parameter int NUM_LANES = 8,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int WARP_W    = 3,
    parameter int SCB_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_mem_read,
    input  logic                          in_mem_write,
    input  logic                          in_shared_global_bar,
    input  logic [NUM_LANES-1:0]          in_pam,
    input  logic [WARP_W-1:0]             in_warp_id,
    input  logic [SCB_W-1:0]              in_scb_id,
    input  logic [NUM_LANES*DATA_W-1:0]   in_rs_data,
    input  logic [NUM_LANES*DATA_W-1:0]   in_rt_data,
    input  logic [15:0]                   in_offset,
    input  logic [4:0]                    in_reg_addr,
    input  logic [31:0]                   in_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_mem_read,
    output logic                          out_mem_write,
    output logic                          out_shared_global_bar,
    output logic [NUM_LANES-1:0]          out_pam,
    output logic [WARP_W-1:0]             out_warp_id,
    output logic [SCB_W-1:0]              out_scb_id,
    output logic [NUM_LANES*DATA_W-1:0]   out_eff_addr,
    output logic [NUM_LANES*DATA_W-1:0]   out_write_data,
    output logic [4:0]                    out_reg_addr,
    output logic [31:0]                   out_instr,
    output logic                          out_uniform,
    output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef MEM_REQ_QUEUE_STATS_EN
   ,output logic [$clog2(DEPTH+1)-1:0]    hw_mark,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = NUM_LANES * DATA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                 memRead_q  [DEPTH];
    logic                 memWrite_q [DEPTH];
    logic                 sgBar_q    [DEPTH];
    logic [NUM_LANES-1:0] pam_q      [DEPTH];
    logic [WARP_W-1:0]    warp_q     [DEPTH];
    logic [SCB_W-1:0]     scb_q      [DEPTH];
    logic [LW-1:0]        effAddr_q  [DEPTH];
    logic [LW-1:0]        wdata_q    [DEPTH];
    logic [4:0]           regAddr_q  [DEPTH];
    logic [31:0]          instr_q    [DEPTH];
    logic                 uniform_q  [DEPTH];

    logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic              enq, deq;
    logic [DATA_W-1:0] offsetExt, laneAddr, refAddr;
    logic              refFound, uniformIn;
    logic [LW-1:0]     effAddrIn;

    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q < DEPTH_C) | out_ready;
    assign enq       = in_valid & in_ready & (in_mem_read | in_mem_write);
    assign deq       = out_valid & out_ready;

    // Lane addresses are independent adds; uniformity compares active lanes to the first active one.
    always_comb begin
        offsetExt = {{(DATA_W-16){in_offset[15]}}, in_offset};
        laneAddr  = '0;
        refAddr   = '0;
        refFound  = 1'b0;
        uniformIn = 1'b1;
        effAddrIn = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            laneAddr = in_rs_data[i*DATA_W +: DATA_W] + offsetExt;
            effAddrIn[i*DATA_W +: DATA_W] = laneAddr;
            if (in_pam[i]) begin
                if (!refFound) begin
                    refAddr  = laneAddr;
                    refFound = 1'b1;
                end else if (laneAddr != refAddr) begin
                    uniformIn = 1'b0;
                end
            end
        end
    end

    always_comb begin
        wrPtr_d = enq ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = deq ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Uniform resets to 1 so an empty queue after reset presents out_uniform=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                memRead_q[e]  <= 1'b0;
                memWrite_q[e] <= 1'b0;
                sgBar_q[e]    <= 1'b0;
                pam_q[e]      <= '0;
                warp_q[e]     <= '0;
                scb_q[e]      <= '0;
                effAddr_q[e]  <= '0;
                wdata_q[e]    <= '0;
                regAddr_q[e]  <= '0;
                instr_q[e]    <= '0;
                uniform_q[e]  <= 1'b1;
            end
        end else if (enq) begin
            memRead_q[wrPtr_q]  <= in_mem_read & ~in_mem_write;
            memWrite_q[wrPtr_q] <= in_mem_write;
            sgBar_q[wrPtr_q]    <= in_shared_global_bar;
            pam_q[wrPtr_q]      <= in_pam;
            warp_q[wrPtr_q]     <= in_warp_id;
            scb_q[wrPtr_q]      <= in_scb_id;
            effAddr_q[wrPtr_q]  <= effAddrIn;
            wdata_q[wrPtr_q]    <= in_rt_data;
            regAddr_q[wrPtr_q]  <= in_reg_addr;
            instr_q[wrPtr_q]    <= in_instr;
            uniform_q[wrPtr_q]  <= uniformIn;
        end
    end

    assign out_mem_read          = memRead_q[rdPtr_q];
    assign out_mem_write         = memWrite_q[rdPtr_q];
    assign out_shared_global_bar = sgBar_q[rdPtr_q];
    assign out_pam               = pam_q[rdPtr_q];
    assign out_warp_id           = warp_q[rdPtr_q];
    assign out_scb_id            = scb_q[rdPtr_q];
    assign out_eff_addr          = effAddr_q[rdPtr_q];
    assign out_write_data        = wdata_q[rdPtr_q];
    assign out_reg_addr          = regAddr_q[rdPtr_q];
    assign out_instr             = instr_q[rdPtr_q];
    assign out_uniform           = uniform_q[rdPtr_q];
    assign count                 = count_q;

`ifdef MEM_REQ_QUEUE_STATS_EN
    logic [CW-1:0] hwMark_q, hwMark_d;
    logic [15:0]   stallCnt_q, stallCnt_d;

    always_comb begin
        hwMark_d   = (count_q > hwMark_q) ? count_q : hwMark_q;
        stallCnt_d = stallCnt_q;
        if (in_valid && !in_ready && stallCnt_q != 16'hFFFF) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hwMark_q   <= '0;
            stallCnt_q <= '0;
        end else begin
            hwMark_q   <= hwMark_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign hw_mark   = hwMark_q;
    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: doc/mem_req_queue.md
# mem_req_queue

Parametrised request queue that sits between the operand collector and mem stage 1. It replaces the single unconditional capture register with a DEPTH-entry FIFO and a valid/ready handshake on both sides. Per-lane effective addresses (rs + sign-extended offset) and a uniform-address flag are computed at enqueue. The stage-1 pipeline therefore receives address-ready requests and can apply backpressure.

## Interface
Parameters:
- NUM_LANES, 8, threads per warp (lane count)
- DATA_W, 32, bits per lane for rs/rt/address
- DEPTH, 4, queue entries; power of two, ≥2
- WARP_W, 3, warp ID width
- SCB_W, 2, scoreboard ID width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  request offered by operand collector
- in_ready  out  1  queue can accept this cycle
- in_mem_read, in_mem_write, in_shared_global_bar  in  1 each  request type
- in_pam  in  NUM_LANES  active-lane mask
- in_warp_id  in  WARP_W; in_scb_id  in  SCB_W
- in_rs_data, in_rt_data  in  NUM_LANES*DATA_W  base / store data, lane i at [i*DATA_W +: DATA_W]
- in_offset  in  16  signed immediate
- in_reg_addr  in  5; in_instr  in  32
- out_valid  out  1  head entry present
- out_ready  in  1  stage 1 accepts head
- out_mem_read, out_mem_write, out_shared_global_bar  out  1 each
- out_pam  out  NUM_LANES; out_warp_id  out  WARP_W; out_scb_id  out  SCB_W
- out_eff_addr, out_write_data  out  NUM_LANES*DATA_W
- out_reg_addr  out  5; out_instr  out  32
- out_uniform  out  1  all active lanes share one address
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Enqueue fires when in_valid & in_ready & (in_mem_read | in_mem_write). in_valid with neither read nor write set is accepted and discarded; it is not stored.
- in_mem_read & in_mem_write both set: the request is stored with out_mem_write=1 and out_mem_read=0. Write wins.
- Per lane: eff_addr[i] = rs[i] + {{(DATA_W-16){offset[15]}}, offset}, modulo 2^DATA_W. Carries do not cross lanes. Address is computed for all lanes regardless of PAM.
- out_uniform = 1 when every lane with pam[i]=1 has the same eff_addr. If pam=0, out_uniform=1.
- Dequeue fires when out_valid & out_ready. Head fields are driven from registered storage; no combinational path from in_* to out_*.
- in_ready = (count < DEPTH) | out_ready. When full, a same-cycle dequeue frees the slot for a simultaneous enqueue.
- Pointers are log2(DEPTH) bits and wrap naturally. count = +1 on enqueue only, −1 on dequeue only, unchanged when both fire.
- Ordering is strict FIFO across all warps.

## Timing
- Latency in→out is 1 cycle: an entry enqueued at edge N is visible at out_* after edge N.
- Throughput is 1 request/cycle at any occupancy, including full with out_ready=1.
- Reset values:
  - count=0, out_valid=0, in_ready=1, pointers 0.
  - out_mem_read=0, out_mem_write=0, out_uniform=1.
  - All other out_* are 0; storage is cleared.
- rst mid-operation drops every queued entry. in_valid coincident with rst is ignored.
- out_* fields are stable while out_valid & !out_ready.
- in_ready depends combinationally on out_ready only.

## Configuration
- MEM_REQ_QUEUE_STATS_EN defined:
  - Adds outputs hw_mark ($clog2(DEPTH+1)): maximum count since reset, updated the cycle after count changes.
  - Adds stall_cnt (16): cycles with in_valid & !in_ready; saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Single load, warp 3, rs lane i = 0x100+4i, offset 0xFFFC, pam=0xFF → out_valid one cycle later; eff_addr lane i = 0xFC+4i; out_uniform=0; count returns to 0 after dequeue.
- out_ready=0, push 5 requests at DEPTH=4 → in_ready=0 after the 4th; 5th is held. Raise out_ready → order is preserved, and the 5th enqueues in the same cycle as the first dequeue (count stays 4).
- rs all lanes = 0x40, offset 0 with pam=0x05 → out_uniform=1. Change lane 1 (inactive) to 0x80 → still 1. Change lane 2 to 0x80 → 0.
- in_valid with read=0, write=0 → count unchanged, out_valid stays 0. Read=1 and write=1 → out_mem_write=1, out_mem_read=0.
- Fill to 3 entries, assert rst for one cycle → count=0, out_valid=0, in_ready=1 next cycle; no stale entry emerges afterwards.
- With MEM_REQ_QUEUE_STATS_EN: hold full with in_valid=1 for 10 cycles → stall_cnt=10, hw_mark=4.
